load_store_unit: RTL and testbench
==================================

LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 Parameter ADDR_W, default 32, address width of core request and data-memory address.
REQ-002 clock  input  1  rising-edge clock, sole clock domain.
REQ-003 reset_n  input  1  asynchronous, active-low reset.
REQ-004 io_req_valid  input  1  core presents a load/store request.
REQ-005 io_req_ready  output  1  unit can accept a request this cycle.
REQ-006 io_req_wen  input  1  1 = store, 0 = load.
REQ-007 io_req_size  input  2  0 = byte, 1 = halfword, 2 = word; 3 is reserved and treated as misaligned.
REQ-008 io_req_unsigned  input  1  zero-extend sub-word loads when set, sign-extend otherwise.
REQ-009 io_req_addr  input  ADDR_W  byte address.
REQ-010 io_req_wdata  input  32  store data, right-justified.
REQ-011 io_resp_valid  output  1  one-cycle completion pulse.
REQ-012 io_resp_rdata  output  32  extended load data; 0 for stores and faults.
REQ-013 io_resp_misaligned  output  1  request faulted; valid only with io_resp_valid.
REQ-014 io_dmem_addr  output  ADDR_W  word-aligned data-memory address.
REQ-015 io_dmem_rdata  input  32  little-endian word, combinational from io_dmem_addr.
REQ-016 io_dmem_wen  output  1  write-enable; the memory writes all four bytes on the next rising edge.
REQ-017 io_dmem_wdata  output  32  full word to write.

Function
REQ-018 The FSM SHALL have states IDLE, READ, WRITE and RESP.
REQ-019 In IDLE, io_req_ready SHALL be 1; in every other state it SHALL be 0.
REQ-020 A request SHALL be accepted on the cycle with valid && ready; addr, size, wen, unsigned and wdata SHALL be registered that cycle.
REQ-021 A request SHALL be misaligned when size = 1 with addr[0] = 1, when size = 2 with addr[1:0] != 0, or when size = 3.
REQ-022 Transitions out of IDLE on accept: misaligned -> RESP; word store -> WRITE; any load or sub-word store -> READ.
REQ-023 Transitions out of READ: a load -> RESP; a sub-word store -> WRITE.
REQ-024 WRITE -> RESP and RESP -> IDLE unconditionally.
REQ-025 io_dmem_addr SHALL equal {addr[ADDR_W-1:2], 2'b00} in READ and WRITE, and 0 otherwise.
REQ-026 io_dmem_wen SHALL be 1 only in WRITE, and never for a misaligned request.
REQ-027 In READ, io_dmem_rdata SHALL be captured into a 32-bit word buffer.
REQ-028 Store merge: the byte lane is addr[1:0] and the halfword lane is addr[1]; only the addressed lane(s) of the buffered word are replaced with wdata[7:0] or wdata[15:0]; a word store writes wdata unchanged.
REQ-029 Load extract: select the lane from the buffer, then zero- or sign-extend to 32 bits per io_req_unsigned; a word load returns the buffer unchanged.
REQ-030 Latency from the accept cycle T: load -> io_resp_valid at T+2; word store -> T+2; sub-word store -> T+3; misaligned -> T+1.
REQ-031 io_resp_valid SHALL be high only in RESP, for exactly one cycle per accepted request.
REQ-032 io_resp_rdata and io_resp_misaligned SHALL be registered outputs, stable throughout RESP.
REQ-033 io_req_valid asserted while io_req_ready = 0 SHALL be ignored with no side effects; the core holds the request.
REQ-034 A request presented during RESP SHALL be accepted in the following IDLE cycle, giving back-to-back throughput of one request per 3 cycles for loads.
REQ-035 Address arithmetic SHALL NOT carry; only the low two bits are masked.

Reset
REQ-036 reset_n low SHALL asynchronously force state = IDLE, io_resp_valid = 0, io_resp_rdata = 0, io_resp_misaligned = 0, word buffer = 0 and all captured request registers = 0.
REQ-037 Reset asserted during READ or WRITE SHALL abort the operation with io_dmem_wen = 0 immediately and no response pulse.
REQ-038 After reset release, io_req_ready SHALL be 1 in the first cycle.

Structure
REQ-039 Package lsu_pkg SHALL hold the size encodings (SZ_B, SZ_H, SZ_W) and the FSM state encoding.
REQ-040 A combinational sub-module lsu_byte_lane SHALL implement the lane merge and the extract/extend logic; load_store_unit holds the FSM and registers.

Verification
REQ-041 Memory word at 0x40 = 0x8899AABB; lb 0x41 -> io_resp_rdata = 0xFFFFFFAA at T+2; lbu 0x41 -> 0x000000AA.
REQ-042 lh 0x42 on word 0x8899AABB -> 0xFFFF8899; lhu 0x42 -> 0x00008899.
REQ-043 sb 0x43 with wdata 0x12 on 0x8899AABB -> one write of 0x1299AABB to 0x40 at T+2; io_resp_valid at T+3; no other write pulses.
REQ-044 sw 0x44 with 0xDEADBEEF -> single wen cycle at T+1 with addr 0x44; response at T+2; a following lw 0x44 returns 0xDEADBEEF.
REQ-045 lh 0x45 and lw 0x46 -> io_resp_misaligned = 1 at T+1, io_dmem_wen never asserted, io_resp_rdata = 0.
REQ-046 Assert reset_n = 0 mid-WRITE of sb 0x48 -> io_dmem_wen drops immediately, memory is unchanged, no resp pulse, and io_req_ready = 1 after release.

Source files
------------

// File: rtl/lsu_pkg.sv
// rtl/lsu_pkg.sv - size encodings, FSM state encoding and alignment helper for the load/store unit
//
// Purpose: shared definitions imported by load_store_unit and lsu_byte_lane.
// Contents: SZ_B/SZ_H/SZ_W access-size codes, lsu_state_e FSM states,
//           is_misaligned() alignment check.
package lsu_pkg;

    localparam logic [1:0] SZ_B = 2'd0;
    localparam logic [1:0] SZ_H = 2'd1;
    localparam logic [1:0] SZ_W = 2'd2;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_READ  = 2'd1,
        ST_WRITE = 2'd2,
        ST_RESP  = 2'd3
    } lsu_state_e;

    // The reserved size code 3 is reported as a fault rather than guessed at.
    function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] lo);
        logic mis;
        case (size)
            SZ_B:    mis = 1'b0;
            SZ_H:    mis = lo[0];
            SZ_W:    mis = (lo != 2'b00);
            default: mis = 1'b1;
        endcase
        return mis;
    endfunction

endpackage

// File: rtl/load_store_unit_if.sv
// rtl/load_store_unit_if.sv - core request/response and data-memory signal bundle
//
// Purpose: groups the core-side handshake and the data-memory port.
// Modports: slave  - the load/store unit (accepts requests, drives memory)
//           master - the core/memory environment
// Signals:  io_req_*  core request, io_resp_* completion,
//           io_dmem_* word-wide data-memory port (combinational read).
interface load_store_unit_if #(
    parameter int ADDR_W = 32
);
    logic              io_req_valid;
    logic              io_req_ready;
    logic              io_req_wen;
    logic [1:0]        io_req_size;
    logic              io_req_unsigned;
    logic [ADDR_W-1:0] io_req_addr;
    logic [31:0]       io_req_wdata;

    logic              io_resp_valid;
    logic [31:0]       io_resp_rdata;
    logic              io_resp_misaligned;

    logic [ADDR_W-1:0] io_dmem_addr;
    logic [31:0]       io_dmem_rdata;
    logic              io_dmem_wen;
    logic [31:0]       io_dmem_wdata;

    modport slave (
        input  io_req_valid, io_req_wen, io_req_size, io_req_unsigned,
               io_req_addr, io_req_wdata, io_dmem_rdata,
        output io_req_ready, io_resp_valid, io_resp_rdata, io_resp_misaligned,
               io_dmem_addr, io_dmem_wen, io_dmem_wdata
    );

    modport master (
        output io_req_valid, io_req_wen, io_req_size, io_req_unsigned,
               io_req_addr, io_req_wdata, io_dmem_rdata,
        input  io_req_ready, io_resp_valid, io_resp_rdata, io_resp_misaligned,
               io_dmem_addr, io_dmem_wen, io_dmem_wdata
    );

endinterface

// File: rtl/lsu_byte_lane.sv
// rtl/lsu_byte_lane.sv - combinational store lane merge and load lane extract/extend
//
// Purpose: pure datapath for sub-word accesses on a little-endian 32-bit word.
// Ports: word        in  32  memory word (live read data or buffered copy)
//        wdata       in  32  right-justified store data
//        lane        in  2   low address bits selecting the byte/halfword lane
//        size        in  2   access size (SZ_B/SZ_H/SZ_W)
//        is_unsigned in  1   zero-extend when set, sign-extend otherwise
//        merged      out 32  word to write back for a store
//        extracted   out 32  extended load result
module lsu_byte_lane
    import lsu_pkg::*;
(
    input  logic [31:0] word,
    input  logic [31:0] wdata,
    input  logic [1:0]  lane,
    input  logic [1:0]  size,
    input  logic        is_unsigned,
    output logic [31:0] merged,
    output logic [31:0] extracted
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    always_comb begin
        merged = wdata;
        case (size)
            SZ_B: begin
                merged = word;
                case (lane)
                    2'd0:    merged[7:0]   = wdata[7:0];
                    2'd1:    merged[15:8]  = wdata[7:0];
                    2'd2:    merged[23:16] = wdata[7:0];
                    default: merged[31:24] = wdata[7:0];
                endcase
            end
            SZ_H: merged = lane[1] ? {wdata[15:0], word[15:0]} : {word[31:16], wdata[15:0]};
            default: merged = wdata;
        endcase
    end

    always_comb begin
        case (lane)
            2'd0:    byte_sel = word[7:0];
            2'd1:    byte_sel = word[15:8];
            2'd2:    byte_sel = word[23:16];
            default: byte_sel = word[31:24];
        endcase
        half_sel = lane[1] ? word[31:16] : word[15:0];
        case (size)
            SZ_B:    extracted = is_unsigned ? {24'd0, byte_sel} : {{24{byte_sel[7]}}, byte_sel};
            SZ_H:    extracted = is_unsigned ? {16'd0, half_sel} : {{16{half_sel[15]}}, half_sel};
            default: extracted = word;
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// rtl/load_store_unit.sv - single-outstanding load/store unit with read-modify-write for sub-word stores
//
// Purpose: accepts one core request at a time, performs the word read and/or
//          write on the data memory and returns a one-cycle completion pulse.
// Ports: clock    in  rising-edge clock
//        reset_n  in  asynchronous active-low reset
//        bus      load_store_unit_if.slave (request, response, data memory)
module load_store_unit
    import lsu_pkg::*;
#(
    parameter int ADDR_W = 32
) (
    input  logic                clock,
    input  logic                reset_n,
    load_store_unit_if.slave    bus
);

    lsu_state_e        state;
    logic [ADDR_W-1:0] r_addr;
    logic [1:0]        r_size;
    logic              r_wen;
    logic              r_unsigned;
    logic [31:0]       r_wdata;
    logic [31:0]       word_buf;
    logic              resp_valid;
    logic [31:0]       resp_rdata;
    logic              resp_mis;

    logic [31:0]       lane_word;
    logic [31:0]       merged;
    logic [31:0]       extracted;

    // In READ the live memory word feeds the extractor so the load result can
    // be registered in the same cycle the buffer is filled; in WRITE the
    // buffered copy is merged.
    assign lane_word = (state == ST_READ) ? bus.io_dmem_rdata : word_buf;

    lsu_byte_lane u_lane (
        .word        (lane_word),
        .wdata       (r_wdata),
        .lane        (r_addr[1:0]),
        .size        (r_size),
        .is_unsigned (r_unsigned),
        .merged      (merged),
        .extracted   (extracted)
    );

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state      <= ST_IDLE;
            r_addr     <= '0;
            r_size     <= '0;
            r_wen      <= 1'b0;
            r_unsigned <= 1'b0;
            r_wdata    <= '0;
            word_buf   <= '0;
            resp_valid <= 1'b0;
            resp_rdata <= '0;
            resp_mis   <= 1'b0;
        end else begin
            resp_valid <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (bus.io_req_valid) begin
                        r_addr     <= bus.io_req_addr;
                        r_size     <= bus.io_req_size;
                        r_wen      <= bus.io_req_wen;
                        r_unsigned <= bus.io_req_unsigned;
                        r_wdata    <= bus.io_req_wdata;
                        if (is_misaligned(bus.io_req_size, bus.io_req_addr[1:0])) begin
                            state      <= ST_RESP;
                            resp_valid <= 1'b1;
                            resp_rdata <= '0;
                            resp_mis   <= 1'b1;
                        end else if (bus.io_req_wen && bus.io_req_size == SZ_W) begin
                            state <= ST_WRITE;
                        end else begin
                            state <= ST_READ;
                        end
                    end
                end
                ST_READ: begin
                    word_buf <= bus.io_dmem_rdata;
                    if (r_wen) begin
                        state <= ST_WRITE;
                    end else begin
                        state      <= ST_RESP;
                        resp_valid <= 1'b1;
                        resp_rdata <= extracted;
                        resp_mis   <= 1'b0;
                    end
                end
                ST_WRITE: begin
                    state      <= ST_RESP;
                    resp_valid <= 1'b1;
                    resp_rdata <= '0;
                    resp_mis   <= 1'b0;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.io_req_ready       = (state == ST_IDLE);
    assign bus.io_resp_valid      = resp_valid;
    assign bus.io_resp_rdata      = resp_rdata;
    assign bus.io_resp_misaligned = resp_mis;

    // Decoded from the state register so reset clears the write strobe at once.
    assign bus.io_dmem_addr  = (state == ST_READ || state == ST_WRITE) ? {r_addr[ADDR_W-1:2], 2'b00} : '0;
    assign bus.io_dmem_wen   = (state == ST_WRITE);
    assign bus.io_dmem_wdata = (state == ST_WRITE) ? merged : '0;

endmodule

// File: tb/tb_load_store_unit.sv
// tb/tb_load_store_unit.sv - scoreboard testbench for load_store_unit
module tb_load_store_unit;

    logic clock = 1'b0;
    logic reset_n = 1'b0;
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;

    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    load_store_unit_if #(.ADDR_W(32)) bus ();

    load_store_unit #(.ADDR_W(32)) dut (
        .clock   (clock),
        .reset_n (reset_n),
        .bus     (bus)
    );

    logic [31:0] mem [0:63];
    assign bus.io_dmem_rdata = mem[bus.io_dmem_addr[7:2]];
    always @(posedge clock) if (bus.io_dmem_wen) mem[bus.io_dmem_addr[7:2]] <= bus.io_dmem_wdata;

    typedef struct {
        string       name;
        logic [31:0] rdata;
        logic        mis;
        int          at;
    } resp_t;

    typedef struct {
        string       name;
        logic [31:0] addr;
        logic [31:0] data;
        int          at;
    } wr_t;

    resp_t rq[$];
    wr_t   wq[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Response and write monitors: pop expectations whenever the DUT presents output.
    always @(negedge clock) begin
        if (reset_n) begin
            if (bus.io_resp_valid) begin
                if (rq.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL unexpected_resp: got rdata 0x%08h expected no response", bus.io_resp_rdata);
                end else begin
                    resp_t e;
                    e = rq.pop_front();
                    chk({e.name, "_rdata"}, bus.io_resp_rdata, e.rdata);
                    chk({e.name, "_mis"}, {31'd0, bus.io_resp_misaligned}, {31'd0, e.mis});
                    chk({e.name, "_cycle"}, cyc, e.at);
                end
            end
            if (bus.io_dmem_wen) begin
                if (wq.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL unexpected_write: got addr 0x%08h data 0x%08h expected none", bus.io_dmem_addr, bus.io_dmem_wdata);
                end else begin
                    wr_t w;
                    w = wq.pop_front();
                    chk({w.name, "_waddr"}, bus.io_dmem_addr, w.addr);
                    chk({w.name, "_wdata"}, bus.io_dmem_wdata, w.data);
                    chk({w.name, "_wcycle"}, cyc, w.at);
                end
            end
        end
    end

    // Called on a negedge; holds the request until the unit is ready, then
    // records expectations relative to the accept cycle.
    task automatic issue(input string name, input logic wen, input logic [1:0] size, input logic uns,
                         input logic [31:0] addr, input logic [31:0] wdata,
                         input logic [31:0] exp_rdata, input logic exp_mis, input int lat,
                         input logic has_wr, input logic [31:0] wr_addr, input logic [31:0] wr_data,
                         input int wr_lat);
        int n;
        bus.io_req_valid    = 1'b1;
        bus.io_req_wen      = wen;
        bus.io_req_size     = size;
        bus.io_req_unsigned = uns;
        bus.io_req_addr     = addr;
        bus.io_req_wdata    = wdata;
        n = 0;
        while (!bus.io_req_ready && n < 20) begin
            @(negedge clock);
            n++;
        end
        if (!bus.io_req_ready) begin
            checks++; errors++;
            $display("FAIL %s_accept: got ready 0 expected ready within 20 cycles", name);
        end else begin
            rq.push_back('{name, exp_rdata, exp_mis, cyc + lat});
            if (has_wr) wq.push_back('{name, wr_addr, wr_data, cyc + wr_lat});
        end
        @(negedge clock);
        bus.io_req_valid = 1'b0;
    endtask

    initial begin
        for (int i = 0; i < 64; i++) mem[i] = 32'h0;
        mem[6'h10] = 32'h8899AABB;   // 0x40
        mem[6'h12] = 32'h11223344;   // 0x48
        mem[6'h3F] = 32'h0BADF00D;   // top word, reached by 0xFFFFFFFC
        bus.io_req_valid    = 1'b0;
        bus.io_req_wen      = 1'b0;
        bus.io_req_size     = 2'd0;
        bus.io_req_unsigned = 1'b0;
        bus.io_req_addr     = 32'h0;
        bus.io_req_wdata    = 32'h0;

        repeat (2) @(negedge clock);
        chk("rst_resp_valid", {31'd0, bus.io_resp_valid}, 32'd0);
        chk("rst_resp_rdata", bus.io_resp_rdata, 32'd0);
        chk("rst_resp_mis", {31'd0, bus.io_resp_misaligned}, 32'd0);
        chk("rst_dmem_wen", {31'd0, bus.io_dmem_wen}, 32'd0);
        chk("rst_dmem_addr", bus.io_dmem_addr, 32'd0);
        reset_n = 1'b1;
        chk("rst_ready", {31'd0, bus.io_req_ready}, 32'd1);

        //    name     wen   size  uns   addr          wdata         exp_rdata     mis   lat  wr    wr_addr       wr_data       wr_lat
        issue("lb41",  1'b0, 2'd0, 1'b0, 32'h41,       32'h0,        32'hFFFFFFAA, 1'b0, 2,   1'b0, 32'h0,        32'h0,        0);
        issue("lbu41", 1'b0, 2'd0, 1'b1, 32'h41,       32'h0,        32'h000000AA, 1'b0, 2,   1'b0, 32'h0,        32'h0,        0);
        issue("lh42",  1'b0, 2'd1, 1'b0, 32'h42,       32'h0,        32'hFFFF8899, 1'b0, 2,   1'b0, 32'h0,        32'h0,        0);
        issue("lhu42", 1'b0, 2'd1, 1'b1, 32'h42,       32'h0,        32'h00008899, 1'b0, 2,   1'b0, 32'h0,        32'h0,        0);
        issue("sb43",  1'b1, 2'd0, 1'b0, 32'h43,       32'h12,       32'h0,        1'b0, 3,   1'b1, 32'h40,       32'h1299AABB, 2);
        issue("lb43",  1'b0, 2'd0, 1'b0, 32'h43,       32'h0,        32'h00000012, 1'b0, 2,   1'b0, 32'h0,        32'h0,        0);
        issue("lw40",  1'b0, 2'd2, 1'b0, 32'h40,       32'h0,        32'h1299AABB, 1'b0, 2,   1'b0, 32'h0,        32'h0,        0);
        issue("sw44",  1'b1, 2'd2, 1'b0, 32'h44,       32'hDEADBEEF, 32'h0,        1'b0, 2,   1'b1, 32'h44,       32'hDEADBEEF, 1);
        issue("lw44",  1'b0, 2'd2, 1'b0, 32'h44,       32'h0,        32'hDEADBEEF, 1'b0, 2,   1'b0, 32'h0,        32'h0,        0);
        issue("lh45",  1'b0, 2'd1, 1'b0, 32'h45,       32'h0,        32'h0,        1'b1, 1,   1'b0, 32'h0,        32'h0,        0);
        issue("lw46",  1'b0, 2'd2, 1'b0, 32'h46,       32'h0,        32'h0,        1'b1, 1,   1'b0, 32'h0,        32'h0,        0);
        issue("sh46",  1'b1, 2'd1, 1'b0, 32'h46,       32'h1234CAFE, 32'h0,        1'b0, 3,   1'b1, 32'h44,       32'hCAFEBEEF, 2);
        issue("lb45",  1'b0, 2'd0, 1'b0, 32'h45,       32'h0,        32'hFFFFFFBE, 1'b0, 2,   1'b0, 32'h0,        32'h0,        0);
        issue("sz3",   1'b0, 2'd3, 1'b0, 32'h40,       32'h0,        32'h0,        1'b1, 1,   1'b0, 32'h0,        32'h0,        0);
        issue("sh41",  1'b1, 2'd1, 1'b0, 32'h41,       32'hFFFF,     32'h0,        1'b1, 1,   1'b0, 32'h0,        32'h0,        0);
        issue("lbuFF", 1'b0, 2'd0, 1'b1, 32'hFFFFFFFF, 32'h0,        32'h0000000B, 1'b0, 2,   1'b0, 32'h0,        32'h0,        0);
        issue("sbFE",  1'b1, 2'd0, 1'b0, 32'hFFFFFFFE, 32'h77,       32'h0,        1'b0, 3,   1'b1, 32'hFFFFFFFC, 32'h0B77F00D, 2);

        for (int n = 0; n < 20 && (rq.size() != 0 || wq.size() != 0); n++) @(negedge clock);
        chk("resp_queue_drained", rq.size(), 32'd0);
        chk("write_queue_drained", wq.size(), 32'd0);

        // Reset in the middle of the WRITE phase of sb 0x48.
        @(negedge clock);
        bus.io_req_valid = 1'b1;
        bus.io_req_wen   = 1'b1;
        bus.io_req_size  = 2'd0;
        bus.io_req_addr  = 32'h48;
        bus.io_req_wdata = 32'h55;
        chk("sb48_ready", {31'd0, bus.io_req_ready}, 32'd1);
        @(posedge clock);
        @(posedge clock);
        #2;
        bus.io_req_valid = 1'b0;
        chk("sb48_in_write", {31'd0, bus.io_dmem_wen}, 32'd1);
        reset_n = 1'b0;
        #1;
        chk("sb48_wen_dropped", {31'd0, bus.io_dmem_wen}, 32'd0);
        chk("sb48_no_resp", {31'd0, bus.io_resp_valid}, 32'd0);
        repeat (2) @(negedge clock);
        reset_n = 1'b1;
        chk("post_rst_ready", {31'd0, bus.io_req_ready}, 32'd1);
        repeat (4) @(negedge clock);
        chk("sb48_mem_unchanged", mem[6'h12], 32'h11223344);
        chk("post_rst_idle", {31'd0, bus.io_req_ready}, 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
